// File: rtl/decoder_controller.sv
// rtl/decoder_controller.sv - control FSM for the permutation decoder
// Loads a state, runs ROUNDS inverse rounds (ROUNDS-1 down to 0) of five step units, then streams the result out.
module decoder_controller #(
  parameter int SLICES = 64,
  parameter int ROUNDS = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ready,
  output logic                      putInput,
  output logic                      outReady,
  output logic                      memRead,
  output logic                      memWrite,
  output logic [2:0]                memSrc,
  output logic [$clog2(SLICES)-1:0] sliceIdx,
  output logic [4:0]                roundIdx,
  output logic [4:0]                stepStart,
  input  logic [4:0]                stepReady,
  input  logic [4:0]                stepPutInput,
  input  logic [4:0]                stepOutReady
);
  localparam int SW = $clog2(SLICES);
  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
  localparam logic [4:0]    LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [2:0]    LAST_STEP  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_STEP_RDY,
    S_STEP_START,
    S_WAIT_IN,
    S_STREAM,
    S_WAIT_OUT,
    S_WRITE,
    S_ROUND_END,
    S_INFORM,
    S_RESULT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [SW-1:0] r_slice;
  logic [4:0]    r_round;
  logic [2:0]    r_step;
  logic [4:0]    w_step_oh;
  logic          w_rdy;
  logic          w_put;
  logic          w_out;
  logic          w_last;

  // Only the handshake bit of the active unit is ever looked at.
  assign w_step_oh = 5'b00001 << r_step;
  assign w_rdy     = |(stepReady & w_step_oh);
  assign w_put     = |(stepPutInput & w_step_oh);
  assign w_out     = |(stepOutReady & w_step_oh);
  assign w_last    = (r_slice == LAST_SLICE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_slice <= '0;
      r_round <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_INIT: begin
          r_slice <= '0;
          r_round <= LAST_ROUND;
          r_step  <= '0;
        end
        S_LOAD, S_STREAM, S_RESULT: r_slice <= w_last ? '0 : r_slice + SW'(1);
        S_WRITE: begin
          r_slice <= w_last ? '0 : r_slice + SW'(1);
          if (w_last && r_step != LAST_STEP) r_step <= r_step + 3'd1;
        end
        S_STEP_START, S_WAIT_OUT, S_INFORM: r_slice <= '0;
        S_ROUND_END: begin
          r_step <= '0;
          if (r_round != 5'd0) r_round <= r_round - 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = S_INIT;
      S_INIT:       w_next = S_LOAD;
      S_LOAD:       if (w_last) w_next = S_STEP_RDY;
      S_STEP_RDY:   if (w_rdy) w_next = S_STEP_START;
      S_STEP_START: if (!w_rdy) w_next = S_WAIT_IN;
      S_WAIT_IN:    if (w_put) w_next = S_STREAM;
      S_STREAM:     if (w_last) w_next = S_WAIT_OUT;
      S_WAIT_OUT:   if (w_out) w_next = S_WRITE;
      S_WRITE:      if (w_last) w_next = (r_step == LAST_STEP) ? S_ROUND_END : S_STEP_RDY;
      S_ROUND_END:  w_next = (r_round == 5'd0) ? S_INFORM : S_STEP_RDY;
      S_INFORM:     w_next = S_RESULT;
      S_RESULT:     if (w_last) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    putInput  = 1'b0;
    outReady  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memSrc    = 3'd0;
    stepStart = 5'd0;
    case (r_state)
      S_IDLE:       ready = 1'b1;
      S_INIT:       putInput = 1'b1;
      S_LOAD:       memWrite = 1'b1;
      S_STEP_START: stepStart = w_step_oh;
      S_STREAM:     memRead = 1'b1;
      S_WRITE: begin
        memWrite = 1'b1;
        memSrc   = r_step + 3'd1;
      end
      S_INFORM:     outReady = 1'b1;
      S_RESULT:     memRead = 1'b1;
      default: ;
    endcase
  end

  assign sliceIdx = r_slice;
  assign roundIdx = r_round;

endmodule

// File: tb/tb_decoder_controller.sv
// tb/tb_decoder_controller.sv - self-checking bench for decoder_controller
// Step units are modelled in-bench; a scoreboard holds the expected (round, step) start sequence.
module tb_decoder_controller;
  localparam int SLICES  = 64;
  localparam int ROUNDS  = 24;
  localparam int SW      = $clog2(SLICES);
  localparam int MIN_LAT = 15994;
  localparam int LIMIT   = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic          putInput;
  logic          outReady;
  logic          memRead;
  logic          memWrite;
  logic [2:0]    memSrc;
  logic [SW-1:0] sliceIdx;
  logic [4:0]    roundIdx;
  logic [4:0]    stepStart;
  logic [4:0]    stepReady;
  logic [4:0]    stepPutInput;
  logic [4:0]    stepOutReady;
  logic [4:0]    ready_force;
  logic [4:0]    put_en;
  logic [4:0]    out_en;

  decoder_controller #(.SLICES(SLICES), .ROUNDS(ROUNDS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .putInput     (putInput),
    .outReady     (outReady),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memSrc       (memSrc),
    .sliceIdx     (sliceIdx),
    .roundIdx     (roundIdx),
    .stepStart    (stepStart),
    .stepReady    (stepReady),
    .stepPutInput (stepPutInput),
    .stepOutReady (stepOutReady)
  );

  always #5 clk = ~clk;

  // Minimum-response units: ready drops while being started, input/output handshakes gated by the bench.
  assign stepReady    = ~stepStart | ready_force;
  assign stepPutInput = put_en;
  assign stepOutReady = out_en;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb[$];
  int         wr_cnt[6];
  int         rd_cnt, put_cnt, inf_cnt, start_pulses, burst_pos;
  logic [4:0] prev_start;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 6; i++) wr_cnt[i] = 0;
    rd_cnt = 0; put_cnt = 0; inf_cnt = 0; start_pulses = 0; burst_pos = 0;
    prev_start = 5'd0;
  endtask

  task automatic push_expected();
    for (int r = ROUNDS - 1; r >= 0; r--)
      for (int s = 0; s < 5; s++) sb.push_back({5'(r), 3'(s)});
  endtask

  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (stepStart != 5'd0 && prev_start == 5'd0) begin
      start_pulses++;
      expect_eq("start_onehot", $countones(stepStart), 1);
      expect_eq("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        expect_eq("step_order", oh_idx(stepStart), e[2:0]);
        expect_eq("round_at_start", roundIdx, e[7:3]);
      end
    end
    prev_start = stepStart;
    if (memWrite) begin
      if (memSrc <= 3'd5) wr_cnt[int'(memSrc)]++;
      else expect_eq("memsrc_range", memSrc, 5);
    end
    if (memRead) rd_cnt++;
    if (putInput) put_cnt++;
    if (outReady) inf_cnt++;
    if (memRead || memWrite) begin
      expect_eq("slice_seq", sliceIdx, burst_pos);
      burst_pos++;
    end else if (burst_pos != 0) begin
      expect_eq("burst_len", burst_pos, SLICES);
      burst_pos = 0;
    end
  endtask

  task automatic check_idle(input string tag);
    expect_eq({tag, "_ready"}, ready, 1);
    expect_eq({tag, "_putInput"}, putInput, 0);
    expect_eq({tag, "_outReady"}, outReady, 0);
    expect_eq({tag, "_memRead"}, memRead, 0);
    expect_eq({tag, "_memWrite"}, memWrite, 0);
    expect_eq({tag, "_memSrc"}, memSrc, 0);
    expect_eq({tag, "_stepStart"}, stepStart, 0);
    expect_eq({tag, "_sliceIdx"}, sliceIdx, 0);
    expect_eq({tag, "_roundIdx"}, roundIdx, 0);
  endtask

  task automatic check_totals(input string tag);
    expect_eq({tag, "_sb_drained"}, sb.size(), 0);
    expect_eq({tag, "_start_pulses"}, start_pulses, 5 * ROUNDS);
    expect_eq({tag, "_writes_host"}, wr_cnt[0], SLICES);
    for (int s = 1; s <= 5; s++)
      expect_eq($sformatf("%s_writes_src%0d", tag, s), wr_cnt[s], ROUNDS * SLICES);
    expect_eq({tag, "_reads"}, rd_cnt, (5 * ROUNDS + 1) * SLICES);
    expect_eq({tag, "_putInput_cycles"}, put_cnt, 1);
    expect_eq({tag, "_outReady_cycles"}, inf_cnt, 1);
  endtask

  // Plain decode with a spurious start pulse during the first STREAM burst.
  task automatic run_plain(input string name);
    int lat;
    int spur;
    clear_stats();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_eq({name, "_init"}, putInput, 1);
    expect_eq({name, "_ready_low"}, ready, 0);
    lat = 0;
    spur = 0;
    while (!ready && lat < LIMIT) begin
      tick();
      lat++;
      if (spur == 0 && memRead) begin
        start = 1'b1;
        spur = 1;
      end else if (spur == 1) begin
        start = 1'b0;
        spur = 2;
      end
    end
    start = 1'b0;
    expect_eq({name, "_latency"}, lat, MIN_LAT);
    check_totals(name);
  endtask

  initial begin
    int lat, phase, k, n, found;
    rst = 1'b1; start = 1'b0;
    ready_force = 5'd0; put_en = 5'h1f; out_en = 5'h1f;
    clear_stats();
    #2 rst = 1'b0;
    #1 check_idle("rst_async");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_plain("d1");

    // Stalled decode: step 2 start held 5 cycles, step 3 input stalled 6 cycles with bit 0 toggling,
    // step 3 output delayed 10 cycles; start held high throughout.
    clear_stats();
    push_expected();
    ready_force = 5'b00100; put_en = 5'b10111; out_en = 5'b10111;
    start = 1'b1;
    tick();
    expect_eq("d2_init", putInput, 1);
    lat = 0; phase = 0; k = 0;
    while (!ready && lat < LIMIT) begin
      tick();
      lat++;
      case (phase)
        0: if (stepStart[2]) begin k = 1; phase = 1; end
        1: begin
          k++;
          expect_eq("ss2_held", stepStart[2], 1);
          if (k == 5) begin ready_force[2] = 1'b0; phase = 2; end
        end
        2: begin expect_eq("ss2_released", stepStart[2], 0); phase = 3; end
        3: if (stepStart[3]) begin k = 0; phase = 4; end
        4: begin
          k++;
          expect_eq("wait_in_hold", memRead, 0);
          put_en[0] = ~put_en[0];
          if (k == 6) begin put_en[3] = 1'b1; put_en[0] = 1'b1; phase = 5; end
        end
        5: begin expect_eq("stream_after_put", memRead, 1); phase = 6; end
        6: if (!memRead) begin
          k = 1;
          expect_eq("wait_out_hold", memWrite, 0);
          phase = 7;
        end
        7: begin
          k++;
          expect_eq("wait_out_hold", memWrite, 0);
          if (k == 10) begin out_en[3] = 1'b1; phase = 8; end
        end
        8: begin
          expect_eq("write_after_out", memWrite, 1);
          expect_eq("write_src_step3", memSrc, 4);
          phase = 9;
        end
        default: ;
      endcase
    end
    expect_eq("d2_latency", lat, MIN_LAT + 18);
    expect_eq("d2_stall_phases", phase, 9);
    check_totals("d2");

    // start still high: a new decode begins one cycle after IDLE
    clear_stats();
    push_expected();
    ready_force = 5'd0; put_en = 5'h1f; out_en = 5'h1f;
    tick();
    expect_eq("restart_init", putInput, 1);
    start = 1'b0;
    found = 0; n = 0;
    while (found == 0 && n < LIMIT) begin
      tick();
      n++;
      if (memWrite && memSrc != 3'd0 && roundIdx == 5'd10) found = 1;
    end
    expect_eq("abort_point_found", found, 1);
    #2 rst = 1'b0;
    #1 check_idle("rst_midop");
    sb.delete();
    clear_stats();
    repeat (3) begin
      @(negedge clk);
      expect_eq("no_strobe_in_rst", {memRead, memWrite, stepStart}, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    expect_eq("idle_after_abort", ready, 1);

    run_plain("d4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
